// File: rtl/wash_controller.sv
// Coin-operated washing-machine sequencer: IDLE -> FILL -> WASH -> RINSE
// (-> WASH -> RINSE on a double wash) -> SPIN -> IDLE. Each phase lasts
// minutes*60*BASE_HZ*2^clk_freq clock cycles. wash_done is registered: it
// rises when SPIN ends and stays high in IDLE until the next coin.
// Optional feature macro: WASH_TIMER_PAUSE_EN (when defined, timer_pause
// freezes the SPIN timer; otherwise timer_pause is ignored).
module wash_controller #(
  parameter int BASE_HZ = 1000000,
  parameter int CNT_W   = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] clk_freq,
  input  logic       coin_in,
  input  logic       double_wash,
  input  logic       timer_pause,
  output logic       wash_done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FILL  = 3'd1;
  localparam logic [2:0] S_WASH  = 3'd2;
  localparam logic [2:0] S_RINSE = 3'd3;
  localparam logic [2:0] S_SPIN  = 3'd4;

  // Phase lengths at clk_freq = 00, in cycles (minutes * 60 * BASE_HZ).
  localparam logic [CNT_W-1:0] FILL_BASE  = CNT_W'(longint'(BASE_HZ) * 120);
  localparam logic [CNT_W-1:0] WASH_BASE  = CNT_W'(longint'(BASE_HZ) * 300);
  localparam logic [CNT_W-1:0] RINSE_BASE = CNT_W'(longint'(BASE_HZ) * 120);
  localparam logic [CNT_W-1:0] SPIN_BASE  = CNT_W'(longint'(BASE_HZ) * 60);

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             dbl_q, dbl_d;
  logic             pass_q, pass_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] phaseBase;
  logic [CNT_W-1:0] termCount;
  logic             phaseEnd;
  logic             pauseActive;
  logic             spinHold;

`ifdef WASH_TIMER_PAUSE_EN
  assign pauseActive = timer_pause;
`else
  logic unusedPause;
  assign unusedPause = timer_pause;
  assign pauseActive = 1'b0;
`endif

  // Pick the base duration of the current phase.
  always_comb begin
    phaseBase = '0;
    case (state_q)
      S_FILL:  phaseBase = FILL_BASE;
      S_WASH:  phaseBase = WASH_BASE;
      S_RINSE: phaseBase = RINSE_BASE;
      S_SPIN:  phaseBase = SPIN_BASE;
      default: phaseBase = '0;
    endcase
  end

  // clk_freq is live, so a mid-phase decrease makes the >= compare end the
  // phase on the very next cycle instead of wrapping the timer.
  assign termCount = phaseBase << clk_freq;
  assign phaseEnd  = (timer_q >= (termCount - CNT_W'(1)));
  assign spinHold  = pauseActive && (state_q == S_SPIN);

  // Next-state, timer, pass bookkeeping and completion flag.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dbl_d   = dbl_q;
    pass_d  = pass_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (coin_in) begin
          state_d = S_FILL;
          timer_d = '0;
          dbl_d   = double_wash;
          pass_d  = 1'b0;
          done_d  = 1'b0;
        end
      end
      S_FILL, S_WASH, S_RINSE, S_SPIN: begin
        if (!spinHold) begin
          if (phaseEnd) begin
            timer_d = '0;
            case (state_q)
              S_FILL:  state_d = S_WASH;
              S_WASH:  state_d = S_RINSE;
              S_RINSE: begin
                if (dbl_q && !pass_q) begin
                  state_d = S_WASH;
                  pass_d  = 1'b1;
                end else begin
                  state_d = S_SPIN;
                end
              end
              default: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
              end
            endcase
          end else begin
            timer_d = timer_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      dbl_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dbl_q   <= dbl_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  assign wash_done = done_q;

endmodule

// File: tb/tb_wash_controller.sv
// Directed bench for wash_controller with BASE_HZ=10, so one minute is 600
// cycles at clk_freq=00. Expected cycle counts are hand-computed:
// single = 1200+3000+1200+600 = 6000, double = 10200, 8x single = 48000.
module tb_wash_controller;

  logic       clk;
  logic       rst_n;
  logic [1:0] clk_freq;
  logic       coin_in;
  logic       double_wash;
  logic       timer_pause;
  logic       wash_done;

  int checks;
  int failures;

  wash_controller #(
    .BASE_HZ(10),
    .CNT_W  (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_freq   (clk_freq),
    .coin_in    (coin_in),
    .double_wash(double_wash),
    .timer_pause(timer_pause),
    .wash_done  (wash_done)
  );

  // Free-running 10-time-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts every comparison and reports any mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic coin, input logic dbl, input logic [1:0] freq,
                               input logic pause);
    coin_in     = coin;
    double_wash = dbl;
    clk_freq    = freq;
    timer_pause = pause;
  endtask

  // Advance one rising edge and settle 1 unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickN(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Counts edges from startN until wash_done rises (bounded), checks it is
  // still low one edge early, then compares the edge count to expected.
  task automatic waitDone(input string tag, input int startN, input int expected);
    int n;
    n = startN;
    while (n < expected + 100) begin
      tick();
      n++;
      if (n == expected - 1) checkOutput({tag, "_low_before"}, int'(wash_done), 0);
      if (wash_done) break;
    end
    checkOutput(tag, n, expected);
  endtask

  initial begin
    int sawHigh;
    int pauseDelay;
    checks   = 0;
    failures = 0;
`ifdef WASH_TIMER_PAUSE_EN
    pauseDelay = 100;
`else
    pauseDelay = 0;
`endif

    // Reset and idle with all inputs low.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    tickN(3);
    checkOutput("reset_done", int'(wash_done), 0);
    rst_n = 1'b1;
    sawHigh = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (wash_done) sawHigh = 1;
    end
    checkOutput("idle_1000", sawHigh, 0);

    // Single cycle with a one-cycle coin pulse.
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("single_accept", int'(wash_done), 0);
    tickN(10);
    checkOutput("single_n10", int'(wash_done), 0);
    tickN(1190);
    checkOutput("single_fill_end", int'(wash_done), 0);
    tickN(3000);
    checkOutput("single_wash_end", int'(wash_done), 0);
    tickN(1200);
    checkOutput("single_rinse_end", int'(wash_done), 0);
    tickN(599);
    checkOutput("single_n5999", int'(wash_done), 0);
    tick();
    checkOutput("single_n6000", int'(wash_done), 1);
    tickN(5);
    checkOutput("single_done_hold", int'(wash_done), 1);

    // Double cycle; double_wash changes after acceptance must be ignored.
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    checkOutput("double_clear_on_coin", int'(wash_done), 0);
    tickN(50);
    applyStimulus(1'b0, 1'b1, 2'b00, 1'b0);
    waitDone("double_done", 50, 10200);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);

    // Async reset while wash_done is high, away from any clock edge.
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_done", int'(wash_done), 0);
    tick();
    rst_n = 1'b1;

    // Reset mid-WASH, then a fresh coin must run a full cycle.
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    tickN(2000);
    rst_n = 1'b0;
    #1;
    checkOutput("midwash_reset_done", int'(wash_done), 0);
    tick();
    rst_n = 1'b1;
    tickN(5);
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    waitDone("restart_full", 0, 6000);

    // Pause for 100 cycles during SPIN (SPIN starts at edge 5400).
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    tickN(5410);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b1);
    tickN(100);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    waitDone("pause_done", 5510, 6000 + pauseDelay);

    // 8x clock with coin held high throughout: done lasts one cycle.
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0);
    tick();
    checkOutput("freq8_accept", int'(wash_done), 0);
    waitDone("freq8_done", 0, 48000);
    tick();
    checkOutput("coin_held_rearm", int'(wash_done), 0);
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0);
    rst_n = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
